// File: rtl/conv1d_mac_sequencer_if.sv
// Signal bundle between the conv1d MAC sequencer and its environment (control, streams, MAC).
// master = environment/controller side, slave = the sequencer itself.
interface conv1d_mac_sequencer_if #(
   parameter int WIDTH_DATA = 8,
   parameter int KERNEL     = 3,
   parameter int LEN_W      = 10
);
   localparam int TAP_W = $clog2(KERNEL);

   logic                    start;
   logic [LEN_W-1:0]        len;
   logic [2*WIDTH_DATA-1:0] bias;
   logic                    w_we;
   logic [TAP_W-1:0]        w_addr;
   logic [WIDTH_DATA-1:0]   w_data;
   logic                    in_valid;
   logic                    in_ready;
   logic [WIDTH_DATA-1:0]   in_data;
   logic [WIDTH_DATA-1:0]   mac_weight;
   logic [WIDTH_DATA-1:0]   mac_feature;
   logic [2*WIDTH_DATA-1:0] mac_psum_in;
   logic [2*WIDTH_DATA-1:0] mac_psum_out;
   logic                    out_valid;
   logic                    out_ready;
   logic [2*WIDTH_DATA-1:0] out_data;
   logic                    busy;
   logic                    done;

   modport master (
      output start, len, bias, w_we, w_addr, w_data,
      output in_valid, in_data, mac_psum_out, out_ready,
      input  in_ready, mac_weight, mac_feature, mac_psum_in,
      input  out_valid, out_data, busy, done
   );

   modport slave (
      input  start, len, bias, w_we, w_addr, w_data,
      input  in_valid, in_data, mac_psum_out, out_ready,
      output in_ready, mac_weight, mac_feature, mac_psum_in,
      output out_valid, out_data, busy, done
   );
endinterface

// File: rtl/conv1d_mac_sequencer.sv
// Steps an external MAC one tap per cycle to compute y[n] = bias + sum w[k]*x[n+k]; result K edges after the window's last sample.
// Input is stalled (in_ready=0) during MAC/OUT; a result is held on out_data until out_ready.
module conv1d_mac_sequencer #(
   parameter int WIDTH_DATA = 8,
   parameter int KERNEL     = 3,
   parameter int LEN_W      = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   conv1d_mac_sequencer_if.slave io_bus
);
   localparam int                 TAP_W    = $clog2(KERNEL);
   localparam int                 PW       = 2 * WIDTH_DATA;
   localparam logic [LEN_W-1:0]   KM1      = LEN_W'(KERNEL - 1);
   localparam logic [TAP_W-1:0]   LAST_TAP = TAP_W'(KERNEL - 1);
   localparam logic [TAP_W:0]     K_TAPS   = (TAP_W + 1)'(KERNEL);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_LOAD,
      S_MAC,
      S_OUT,
      S_FIN
   } state_t;

   state_t                r_state;
   logic [WIDTH_DATA-1:0] r_w   [KERNEL];
   logic [WIDTH_DATA-1:0] r_win [KERNEL];
   logic [PW-1:0]         r_acc;
   logic [PW-1:0]         r_bias;
   logic [LEN_W-1:0]      r_len;
   logic [LEN_W-1:0]      r_count;
   logic [TAP_W-1:0]      r_tap;
   logic                  r_in_ready;
   logic                  r_out_valid;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_in_fire;
   logic                  w_in_mac;
   logic [LEN_W-1:0]      w_count_nxt;

   assign w_in_fire   = io_bus.in_valid & r_in_ready;
   assign w_in_mac    = (r_state == S_MAC);
   assign w_count_nxt = r_count + LEN_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_acc       <= '0;
         r_bias      <= '0;
         r_len       <= '0;
         r_count     <= '0;
         r_tap       <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         for (int i = 0; i < KERNEL; i++) begin
            r_w[i]   <= '0;
            r_win[i] <= '0;
         end
      end else begin
         // Newest sample enters at the top so that after the LOAD shift win[0] holds x[n].
         if (w_in_fire) begin
            for (int i = 0; i < KERNEL - 1; i++) begin
               r_win[i] <= r_win[i+1];
            end
            r_win[KERNEL-1] <= io_bus.in_data;
            r_count         <= w_count_nxt;
         end

         case (r_state)
            S_IDLE: begin
               if (io_bus.w_we && ({1'b0, io_bus.w_addr} < K_TAPS)) begin
                  r_w[io_bus.w_addr] <= io_bus.w_data;
               end
               if (io_bus.start) begin
                  r_len   <= io_bus.len;
                  r_bias  <= io_bus.bias;
                  r_count <= '0;
                  r_busy  <= 1'b1;
                  if (io_bus.len == '0) begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= S_FILL;
                     r_in_ready <= 1'b1;
                  end
               end
            end

            S_FILL: begin
               if (w_in_fire) begin
                  if ((w_count_nxt == KM1) && (r_len > KM1)) begin
                     r_state <= S_LOAD;
                  end else if (w_count_nxt == r_len) begin
                     r_state    <= S_FIN;
                     r_in_ready <= 1'b0;
                     r_done     <= 1'b1;
                  end
               end
            end

            S_LOAD: begin
               if (w_in_fire) begin
                  r_tap      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= S_MAC;
               end
            end

            S_MAC: begin
               r_acc <= io_bus.mac_psum_out;
               if (r_tap == LAST_TAP) begin
                  r_state     <= S_OUT;
                  r_out_valid <= 1'b1;
               end else begin
                  r_tap <= r_tap + TAP_W'(1);
               end
            end

            S_OUT: begin
               if (io_bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_count < r_len) begin
                     r_state    <= S_LOAD;
                     r_in_ready <= 1'b1;
                  end else begin
                     r_state <= S_FIN;
                     r_done  <= 1'b1;
                  end
               end
            end

            S_FIN: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Tap 0 seeds the chain with the bias; later taps feed back the running sum.
   assign io_bus.mac_weight  = w_in_mac ? r_w[r_tap]   : '0;
   assign io_bus.mac_feature = w_in_mac ? r_win[r_tap] : '0;
   assign io_bus.mac_psum_in = w_in_mac ? ((r_tap == '0) ? r_bias : r_acc) : '0;

   assign io_bus.in_ready  = r_in_ready;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.out_data  = r_acc;
   assign io_bus.busy      = r_busy;
   assign io_bus.done      = r_done;
endmodule
